// File: rtl/hub75_rx.sv
// HUB75 receiver: oversamples the panel pins in the clk domain and turns
// them into pixel-shift, line-latch and unblanked-window events.
module hub75_rx #(
   parameter int N_BANKS    = 2,
   parameter int N_ROWS     = 32,
   parameter int N_CHANS    = 3,
   parameter int N_COLS     = 64,
   parameter int ON_W       = 16,
   parameter int LOG_N_ROWS = $clog2(N_ROWS),
   parameter int LOG_N_COLS = $clog2(N_COLS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [LOG_N_ROWS-1:0]        hub75_addr,
   input  logic [N_BANKS*N_CHANS-1:0]   hub75_data,
   input  logic                         hub75_clk,
   input  logic                         hub75_le,
   input  logic                         hub75_blank,
   output logic                         px_valid,
   output logic [LOG_N_COLS-1:0]        px_col,
   output logic [N_BANKS*N_CHANS-1:0]   px_data,
   output logic                         line_valid,
   output logic [LOG_N_ROWS-1:0]        line_addr,
   output logic [LOG_N_COLS:0]          line_len,
   output logic                         line_ovf,
   output logic                         on_valid,
   output logic [ON_W-1:0]              on_cycles,
   output logic [LOG_N_ROWS-1:0]        on_row
);

   localparam int DW = N_BANKS * N_CHANS;
   localparam logic [LOG_N_COLS:0] COLS_LIM = (LOG_N_COLS + 1)'(N_COLS);

   // Saturating increment for the on-time counter.
   function automatic logic [ON_W-1:0] sat_inc(input logic [ON_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [LOG_N_ROWS-1:0] s1_addr, s2_addr;
   logic [DW-1:0]         s1_data, s2_data;
   logic                  s1_clk, s2_clk, s3_clk;
   logic                  s1_le, s2_le, s3_le;
   logic                  s1_blank, s2_blank, s3_blank;

   logic                  rise_clk, rise_le, rise_blank, fall_blank;
   logic                  px_take;
   logic [LOG_N_COLS:0]   col_cnt, col_next;
   logic                  ovf_flag, ovf_next;
   logic [ON_W-1:0]       on_cnt;
   logic                  on_active;
   logic [LOG_N_ROWS-1:0] on_row_cap;

   // Two-stage synchronisers on every pin, plus a third stage for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_addr  <= '0;   s2_addr  <= '0;
         s1_data  <= '0;   s2_data  <= '0;
         s1_clk   <= 1'b0; s2_clk   <= 1'b0; s3_clk   <= 1'b0;
         s1_le    <= 1'b0; s2_le    <= 1'b0; s3_le    <= 1'b0;
         s1_blank <= 1'b1; s2_blank <= 1'b1; s3_blank <= 1'b1;
      end else begin
         s1_addr  <= hub75_addr;  s2_addr  <= s1_addr;
         s1_data  <= hub75_data;  s2_data  <= s1_data;
         s1_clk   <= hub75_clk;   s2_clk   <= s1_clk;   s3_clk   <= s2_clk;
         s1_le    <= hub75_le;    s2_le    <= s1_le;    s3_le    <= s2_le;
         s1_blank <= hub75_blank; s2_blank <= s1_blank; s3_blank <= s2_blank;
      end
   end

   assign rise_clk   = s2_clk & ~s3_clk;
   assign rise_le    = s2_le & ~s3_le;
   assign rise_blank = s2_blank & ~s3_blank;
   assign fall_blank = ~s2_blank & s3_blank;

   // A shift is accepted only while the line still has room; the same-cycle
   // view (col_next/ovf_next) lets a coincident latch include this pixel.
   assign px_take  = rise_clk && (col_cnt < COLS_LIM);
   assign col_next = px_take ? col_cnt + 1'b1 : col_cnt;
   assign ovf_next = ovf_flag | (rise_clk & ~px_take);

   // Pixel event register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         px_valid <= 1'b0;
         px_col   <= '0;
         px_data  <= '0;
      end else begin
         px_valid <= px_take;
         if (px_take) begin
            px_col  <= col_cnt[LOG_N_COLS-1:0];
            px_data <= s2_data;
         end
      end
   end

   // Column counter and overflow flag, cleared by each latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_cnt  <= '0;
         ovf_flag <= 1'b0;
      end else if (rise_le) begin
         col_cnt  <= '0;
         ovf_flag <= 1'b0;
      end else begin
         col_cnt  <= col_next;
         ovf_flag <= ovf_next;
      end
   end

   // Line event register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_valid <= 1'b0;
         line_addr  <= '0;
         line_len   <= '0;
         line_ovf   <= 1'b0;
      end else begin
         line_valid <= rise_le;
         if (rise_le) begin
            line_addr <= s2_addr;
            line_len  <= col_next;
            line_ovf  <= ovf_next;
         end
      end
   end

   // Unblanked-window measurement: the falling-edge cycle counts as the first low cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         on_cnt     <= '0;
         on_active  <= 1'b0;
         on_row_cap <= '0;
         on_valid   <= 1'b0;
         on_cycles  <= '0;
         on_row     <= '0;
      end else begin
         on_valid <= 1'b0;
         if (fall_blank) begin
            on_cnt     <= sat_inc('0);
            on_active  <= 1'b1;
            on_row_cap <= s2_addr;
         end else if (on_active && !s2_blank) begin
            on_cnt <= sat_inc(on_cnt);
         end
         if (rise_blank && on_active) begin
            on_valid  <= 1'b1;
            on_cycles <= on_cnt;
            on_row    <= on_row_cap;
            on_active <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hub75_rx.sv
// Scoreboard bench for hub75_rx: stimulus pushes expected events, a negedge
// monitor pops and compares them, including the 3-cycle event latency.
module tb_hub75_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] hub75_addr;
   logic [5:0] hub75_data;
   logic       hub75_clk, hub75_le, hub75_blank;

   logic       px_valid, line_valid, line_ovf, on_valid;
   logic [5:0] px_col, px_data;
   logic [4:0] line_addr, on_row;
   logic [6:0] line_len;
   logic [15:0] on_cycles;

   logic       b_px_valid, b_line_valid, b_line_ovf, b_on_valid;
   logic [5:0] b_px_col, b_px_data;
   logic [4:0] b_line_addr, b_on_row;
   logic [6:0] b_line_len;
   logic [3:0] b_on_cycles;

   hub75_rx dut (
      .clk(clk), .rst(rst), .hub75_addr(hub75_addr), .hub75_data(hub75_data),
      .hub75_clk(hub75_clk), .hub75_le(hub75_le), .hub75_blank(hub75_blank),
      .px_valid(px_valid), .px_col(px_col), .px_data(px_data),
      .line_valid(line_valid), .line_addr(line_addr), .line_len(line_len), .line_ovf(line_ovf),
      .on_valid(on_valid), .on_cycles(on_cycles), .on_row(on_row)
   );

   hub75_rx #(.ON_W(4)) dut4 (
      .clk(clk), .rst(rst), .hub75_addr(hub75_addr), .hub75_data(hub75_data),
      .hub75_clk(hub75_clk), .hub75_le(hub75_le), .hub75_blank(hub75_blank),
      .px_valid(b_px_valid), .px_col(b_px_col), .px_data(b_px_data),
      .line_valid(b_line_valid), .line_addr(b_line_addr), .line_len(b_line_len), .line_ovf(b_line_ovf),
      .on_valid(b_on_valid), .on_cycles(b_on_cycles), .on_row(b_on_row)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int col; int data; int t; } px_e_t;
   typedef struct { int addr; int len; int ovf; int t; } line_e_t;
   typedef struct { int cycles; int row; int t; } on_e_t;

   px_e_t   px_q[$];
   line_e_t line_q[$];
   on_e_t   on_q[$];
   on_e_t   on4_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input bit ok, input string name, input string act, input string req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %s, expected %s (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One shift pulse: 4 cycles low, 4 high; exp=0 means the DUT should drop it.
   task automatic pix(input int d, input bit exp, input int col);
      px_e_t e;
      hub75_data = 6'(d);
      tick(2);
      hub75_clk = 1'b1;
      if (exp) begin
         e.col = col; e.data = d & 63; e.t = cyc + 3;
         px_q.push_back(e);
      end
      tick(4);
      hub75_clk = 1'b0;
      tick(2);
   endtask

   task automatic latch(input int addr, input int len, input int ovf);
      line_e_t e;
      hub75_addr = 5'(addr);
      tick(2);
      hub75_le = 1'b1;
      e.addr = addr; e.len = len; e.ovf = ovf; e.t = cyc + 3;
      line_q.push_back(e);
      tick(4);
      hub75_le = 1'b0;
      tick(2);
   endtask

   // Blank low for n cycles; address switches halfway through the window.
   task automatic win(input int n, input int a0, input int a1, input int exp4);
      on_e_t e;
      hub75_addr = 5'(a0);
      tick(2);
      hub75_blank = 1'b0;
      tick(n / 2);
      hub75_addr = 5'(a1);
      tick(n - n / 2);
      hub75_blank = 1'b1;
      e.cycles = n; e.row = a0; e.t = cyc + 3;
      on_q.push_back(e);
      e.cycles = exp4;
      on4_q.push_back(e);
      tick(6);
   endtask

   px_e_t   mp;
   line_e_t ml;
   on_e_t   mo;

   // Monitor: every presented event must match the head of its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (px_valid) begin
            if (px_q.size() == 0) chk(1'b0, "px_unexpected", $sformatf("col=%0d", px_col), "no event");
            else begin
               mp = px_q.pop_front();
               chk(int'(px_col) == mp.col && int'(px_data) == mp.data && cyc == mp.t, "px",
                   $sformatf("col=%0d data=%0d t=%0d", px_col, px_data, cyc),
                   $sformatf("col=%0d data=%0d t=%0d", mp.col, mp.data, mp.t));
            end
         end
         if (line_valid) begin
            if (line_q.size() == 0) chk(1'b0, "line_unexpected", $sformatf("len=%0d", line_len), "no event");
            else begin
               ml = line_q.pop_front();
               chk(int'(line_addr) == ml.addr && int'(line_len) == ml.len && int'(line_ovf) == ml.ovf && cyc == ml.t,
                   "line", $sformatf("addr=%0d len=%0d ovf=%0d t=%0d", line_addr, line_len, line_ovf, cyc),
                   $sformatf("addr=%0d len=%0d ovf=%0d t=%0d", ml.addr, ml.len, ml.ovf, ml.t));
            end
         end
         if (on_valid) begin
            if (on_q.size() == 0) chk(1'b0, "on_unexpected", $sformatf("cycles=%0d", on_cycles), "no event");
            else begin
               mo = on_q.pop_front();
               chk(int'(on_cycles) == mo.cycles && int'(on_row) == mo.row && cyc == mo.t, "on",
                   $sformatf("cycles=%0d row=%0d t=%0d", on_cycles, on_row, cyc),
                   $sformatf("cycles=%0d row=%0d t=%0d", mo.cycles, mo.row, mo.t));
            end
         end
         if (b_on_valid) begin
            if (on4_q.size() == 0) chk(1'b0, "on4_unexpected", $sformatf("cycles=%0d", b_on_cycles), "no event");
            else begin
               mo = on4_q.pop_front();
               chk(int'(b_on_cycles) == mo.cycles && int'(b_on_row) == mo.row && cyc == mo.t, "on4",
                   $sformatf("cycles=%0d row=%0d t=%0d", b_on_cycles, b_on_row, cyc),
                   $sformatf("cycles=%0d row=%0d t=%0d", mo.cycles, mo.row, mo.t));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      hub75_addr = '0; hub75_data = '0;
      hub75_clk = 1'b0; hub75_le = 1'b0; hub75_blank = 1'b1;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;

      // Idle after reset: nothing fires, all outputs stay zero.
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk(!px_valid && !line_valid && !on_valid && px_col == 0 && px_data == 0 &&
             line_addr == 0 && line_len == 0 && !line_ovf && on_cycles == 0 && on_row == 0,
             "reset_idle",
             $sformatf("pv=%0d lv=%0d ov=%0d col=%0d len=%0d cyc=%0d", px_valid, line_valid, on_valid, px_col, line_len, on_cycles),
             "all zero");
      end

      // Full line of 64 pixels, latched at row 5.
      for (int i = 0; i < 64; i++) pix(i, 1'b1, i);
      latch(5, 64, 0);

      // 66 shifts: last two dropped, overflow reported; next line is clean.
      for (int i = 0; i < 66; i++) pix(i + 17, i < 64, i);
      latch(9, 64, 1);
      for (int i = 0; i < 10; i++) pix(40 - i, 1'b1, i);
      latch(10, 10, 0);

      // Unblanked windows; the 4-bit instance saturates at 15.
      win(100, 3, 7, 15);
      win(40, 12, 1, 15);
      win(10, 21, 22, 10);

      // Coincident shift and latch after 9 pixels.
      for (int i = 0; i < 9; i++) pix(i, 1'b1, i);
      hub75_data = 6'd9;
      hub75_addr = 5'd2;
      tick(4);
      hub75_clk = 1'b1;
      hub75_le  = 1'b1;
      px_q.push_back('{col: 9, data: 9, t: cyc + 3});
      line_q.push_back('{addr: 2, len: 10, ovf: 0, t: cyc + 3});
      tick(4);
      hub75_clk = 1'b0;
      hub75_le  = 1'b0;
      tick(2);
      for (int i = 0; i < 3; i++) pix(50 + i, 1'b1, i);
      latch(4, 3, 0);

      // Reset in the middle of a line discards it.
      for (int i = 0; i < 30; i++) pix(i, 1'b1, i);
      tick(6);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(4);
      for (int i = 0; i < 5; i++) pix(i + 30, 1'b1, i);
      latch(6, 5, 0);

      tick(10);
      chk(px_q.size() == 0,   "px_drain",   $sformatf("%0d left", px_q.size()),   "0 left");
      chk(line_q.size() == 0, "line_drain", $sformatf("%0d left", line_q.size()), "0 left");
      chk(on_q.size() == 0,   "on_drain",   $sformatf("%0d left", on_q.size()),   "0 left");
      chk(on4_q.size() == 0,  "on4_drain",  $sformatf("%0d left", on4_q.size()),  "0 left");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
